uart_rx_frame: RTL and testbench

Byte receiver that sits directly downstream of the RX start-bit debouncer. It waits for the debouncer's qualified `receive` flag, then times the rest of an 8N1 frame on the raw RX line with a clocks-per-bit counter. It samples each bit at mid-bit, delivers the byte with valid or framing-error strobes, and returns a one-cycle `done` pulse that clears the debouncer for the next frame.

---
 rtl/uart_rx_frame.sv | 148 ++++++++++++++
 tb/tb_uart_rx_frame.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - 8N1 byte receiver timed from the debouncer's qualified start flag
module uart_rx_frame #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int START_OFFSET = 22
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 rx_in,
    input  logic                 receive,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 done,
    output logic                 busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int HALF  = CLKS_PER_BIT / 2 - START_OFFSET;

    localparam logic [CNT_W-1:0] HALF_TERM = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_TERM  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 done_q, done_d;
    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic                 rx_s;

    assign rx_s = sync2_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        idx_d       = idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        done_d      = 1'b0;
        sync1_d     = rx_in;
        sync2_d     = sync1_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (receive) begin
                    state_d = START;
                end
            end
            START: begin
                // Part of the start bit was already spent in the debouncer,
                // so only the remainder up to mid-bit is timed here.
                if (cnt_q == HALF_TERM) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            DATA: begin
                if (cnt_q == BIT_TERM) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d = STOP;
                        idx_d   = '0;
                    end
                end
            end
            STOP: begin
                if (cnt_q == BIT_TERM) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    done_d  = 1'b1;
                    if (rx_s) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            done_q      <= 1'b0;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            done_q      <= done_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign done      = done_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb/tb_uart_rx_frame.sv - directed-vector bench for uart_rx_frame
module tb_uart_rx_frame;

    localparam int CPB = 16;
    localparam int SO  = 2;
    localparam int DB  = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          rx_in = 1'b1;
    logic          receive = 1'b0;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          done;
    logic          busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    int            done_k, done_cnt, valid_cnt, err_cnt, valid_k, valid_cyc;
    logic [DB-1:0] data_at_done;
    logic          busy_after, busy_mid;

    uart_rx_frame #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DB),
        .START_OFFSET(SO)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rx_in    (rx_in),
        .receive  (receive),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .done     (done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Drives one 16-cycle-per-bit frame; receive rises in slot 2 like the debouncer
    // would, and falls when done is seen. Observed edge k is counted from the edge
    // that first samples receive=1.
    task automatic send_frame(input logic [DB-1:0] d, input logic stop, input logic start_bit,
                              input int drop_slot, input int n_slots);
        int done_slot;
        done_k = -1; done_cnt = 0; valid_cnt = 0; err_cnt = 0; valid_k = -1; valid_cyc = -1;
        data_at_done = 'x; busy_after = 1'bx; busy_mid = 1'bx; done_slot = -10;
        for (int c = 0; c < n_slots; c++) begin
            int b;
            b = c / CPB;
            if (b == 0) rx_in = start_bit;
            else if (b <= DB) rx_in = d[b-1];
            else if (b == DB + 1) rx_in = stop;
            else rx_in = 1'b1;
            if (c == 2) receive = 1'b1;
            if (c == drop_slot) receive = 1'b0;
            tick();
            if (c == 80) busy_mid = busy;
            if (c == done_slot + 1) busy_after = busy;
            if (rx_valid) begin valid_cnt++; valid_k = c - 2; valid_cyc = cyc; end
            if (frame_err) err_cnt++;
            if (done) begin
                done_cnt++;
                if (done_k < 0) begin done_k = c - 2; done_slot = c; data_at_done = rx_data; end
                receive = 1'b0;
            end
        end
        rx_in = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; rx_in = 1'b1; receive = 1'b0;
        tick(); tick();
        vectors++;
        if ({rx_data, rx_valid, frame_err, done, busy} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h expected 000", {rx_data, rx_valid, frame_err, done, busy});
        end
        rstn = 1'b1;
        tick(); tick();
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_good_frame();
        send_frame(8'hA5, 1'b1, 1'b0, -1, 176);
        vectors++;
        if (done_k !== 150) begin miscompares++; $display("FAIL t1_done_edge: got %0d expected 150", done_k); end
        vectors++;
        if (done_cnt !== 1) begin miscompares++; $display("FAIL t1_done_width: got %0d expected 1", done_cnt); end
        vectors++;
        if (valid_cnt !== 1 || valid_k !== 150) begin
            miscompares++; $display("FAIL t1_valid: got cnt %0d at %0d expected 1 at 150", valid_cnt, valid_k);
        end
        vectors++;
        if (data_at_done !== 8'hA5) begin miscompares++; $display("FAIL t1_data: got %h expected a5", data_at_done); end
        vectors++;
        if (err_cnt !== 0) begin miscompares++; $display("FAIL t1_frame_err: got %0d expected 0", err_cnt); end
        vectors++;
        if (busy_mid !== 1'b1) begin miscompares++; $display("FAIL t1_busy_mid: got %b expected 1", busy_mid); end
        vectors++;
        if (busy_after !== 1'b0) begin miscompares++; $display("FAIL t1_busy_after: got %b expected 0", busy_after); end
    endtask

    task automatic test_framing_error();
        send_frame(8'h5A, 1'b0, 1'b0, -1, 176);
        vectors++;
        if (err_cnt !== 1) begin miscompares++; $display("FAIL t2_frame_err: got %0d expected 1", err_cnt); end
        vectors++;
        if (done_k !== 150 || done_cnt !== 1) begin
            miscompares++; $display("FAIL t2_done: got edge %0d cnt %0d expected 150 1", done_k, done_cnt);
        end
        vectors++;
        if (valid_cnt !== 0) begin miscompares++; $display("FAIL t2_valid: got %0d expected 0", valid_cnt); end
        vectors++;
        if (rx_data !== 8'hA5) begin miscompares++; $display("FAIL t2_data_hold: got %h expected a5", rx_data); end
    endtask

    task automatic test_false_start();
        send_frame(8'hFF, 1'b1, 1'b1, -1, 40);
        vectors++;
        if (done_k !== 6 || done_cnt !== 1) begin
            miscompares++; $display("FAIL t3_done: got edge %0d cnt %0d expected 6 1", done_k, done_cnt);
        end
        vectors++;
        if (valid_cnt !== 0 || err_cnt !== 0) begin
            miscompares++; $display("FAIL t3_strobes: got valid %0d err %0d expected 0 0", valid_cnt, err_cnt);
        end
        vectors++;
        if (busy_after !== 1'b0) begin miscompares++; $display("FAIL t3_idle: got %b expected 0", busy_after); end
        vectors++;
        if (rx_data !== 8'hA5) begin miscompares++; $display("FAIL t3_data_hold: got %h expected a5", rx_data); end
    endtask

    task automatic test_back_to_back();
        int first_cyc;
        logic [DB-1:0] first_data;
        int first_valid, first_err;
        send_frame(8'h00, 1'b1, 1'b0, -1, 176);
        first_cyc = valid_cyc; first_data = data_at_done; first_valid = valid_cnt; first_err = err_cnt;
        send_frame(8'hFF, 1'b1, 1'b0, -1, 176);
        vectors++;
        if (first_valid !== 1 || first_data !== 8'h00) begin
            miscompares++; $display("FAIL t4_first: got cnt %0d data %h expected 1 00", first_valid, first_data);
        end
        vectors++;
        if (valid_cnt !== 1 || data_at_done !== 8'hFF) begin
            miscompares++; $display("FAIL t4_second: got cnt %0d data %h expected 1 ff", valid_cnt, data_at_done);
        end
        vectors++;
        if (valid_cyc - first_cyc !== 176) begin
            miscompares++; $display("FAIL t4_spacing: got %0d expected 176", valid_cyc - first_cyc);
        end
        vectors++;
        if (first_err + err_cnt !== 0) begin
            miscompares++; $display("FAIL t4_frame_err: got %0d expected 0", first_err + err_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        send_frame(8'h3C, 1'b1, 1'b0, -1, 88);
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL t5_busy_pre: got %b expected 1", busy); end
        rstn = 1'b0;
        #1;
        vectors++;
        if ({rx_data, rx_valid, frame_err, done, busy} !== 12'h000) begin
            miscompares++;
            $display("FAIL t5_async_reset: got %h expected 000", {rx_data, rx_valid, frame_err, done, busy});
        end
        rx_in = 1'b1; receive = 1'b0;
        tick(); tick(); tick();
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++; $display("FAIL t5_held: got busy %b done %b expected 0 0", busy, done);
        end
        rstn = 1'b1;
        tick(); tick();
        send_frame(8'h3C, 1'b1, 1'b0, -1, 176);
        vectors++;
        if (valid_cnt !== 1 || data_at_done !== 8'h3C || done_k !== 150) begin
            miscompares++;
            $display("FAIL t5_recover: got cnt %0d data %h edge %0d expected 1 3c 150", valid_cnt, data_at_done, done_k);
        end
    endtask

    task automatic test_receive_drop();
        send_frame(8'h81, 1'b1, 1'b0, 50, 176);
        vectors++;
        if (valid_cnt !== 1 || data_at_done !== 8'h81) begin
            miscompares++; $display("FAIL t6_data: got cnt %0d data %h expected 1 81", valid_cnt, data_at_done);
        end
        vectors++;
        if (done_k !== 150 || err_cnt !== 0) begin
            miscompares++; $display("FAIL t6_done: got edge %0d err %0d expected 150 0", done_k, err_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_framing_error();
        test_false_start();
        test_back_to_back();
        test_reset_mid_frame();
        test_receive_drop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
